// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl
// Description : Registered scan sequencer for a 3-to-8 decoder stage. Walks
//               the masked channels in ascending order, holds each one for a
//               programmable dwell time and inserts a blanking gap between
//               channels.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl #(
    parameter int DIV_W     = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       mask,
    input  logic [DIV_W-1:0] dwell,
    output logic [2:0]       sel,
    output logic             en_n,
    output logic             busy,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    localparam logic [3:0]       C_BLANK = 4'(BLANK_CYC);
    localparam logic [DIV_W-1:0] C_ONE   = DIV_W'(1);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt,   w_cnt_nxt;
    logic [3:0]       r_bcnt,  w_bcnt_nxt;
    logic [2:0]       w_sel_nxt;
    logic             w_en_n_nxt, w_busy_nxt, w_wrap_nxt;
    logic             w_advance;
    logic [3:0]       w_first;
    logic [3:0]       w_next;
    logic [DIV_W-1:0] w_load;

    // Circular search for the first set mask bit starting at index 'from'.
    // Returns {found, index}; the loop runs downward so the smallest offset
    // is the last one written and therefore wins.
    function automatic logic [3:0] find_from(input logic [7:0] m,
                                             input logic [2:0] from);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = from + 3'(i);
            if (m[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_first = find_from(mask, 3'd0);
    assign w_next  = find_from(mask, sel + 3'd1);
    // A dwell of zero behaves like a dwell of one.
    assign w_load  = (dwell == '0) ? C_ONE : dwell;

    // State register and registered outputs; reset blanks the decoder at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bcnt  <= 4'd0;
            sel     <= 3'd0;
            en_n    <= 1'b1;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            sel     <= w_sel_nxt;
            en_n    <= w_en_n_nxt;
            busy    <= w_busy_nxt;
            wrap    <= w_wrap_nxt;
        end
    end

    // Next-state and next-output logic; stop overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bcnt_nxt  = r_bcnt;
        w_sel_nxt   = sel;
        w_en_n_nxt  = en_n;
        w_busy_nxt  = busy;
        w_wrap_nxt  = 1'b0;
        w_advance   = 1'b0;

        if (stop) begin
            w_state_nxt = S_IDLE;
            w_en_n_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_en_n_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    if (start && w_first[3]) begin
                        w_state_nxt = S_DWELL;
                        w_sel_nxt   = w_first[2:0];
                        w_cnt_nxt   = w_load;
                        w_en_n_nxt  = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_DWELL: begin
                    // Last active cycle of this channel: blank or chain on.
                    if (r_cnt <= C_ONE) begin
                        if (BLANK_CYC > 0) begin
                            w_state_nxt = S_BLANK;
                            w_en_n_nxt  = 1'b1;
                            w_bcnt_nxt  = C_BLANK;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - C_ONE;
                    end
                end
                S_BLANK: begin
                    if (r_bcnt <= 4'd1) begin
                        w_advance = 1'b1;
                    end else begin
                        w_bcnt_nxt = r_bcnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_en_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            endcase

            // Channel hand-over uses the mask as it is right now.
            if (w_advance) begin
                if (w_next[3]) begin
                    w_state_nxt = S_DWELL;
                    w_sel_nxt   = w_next[2:0];
                    w_cnt_nxt   = w_load;
                    w_en_n_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_wrap_nxt  = (w_next[2:0] <= sel);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_en_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/decoder_scan_ctrl.md
# decoder_scan_ctrl

Registered scan sequencer that drives the select and enable inputs of the 3-to-8 decoder stage. It steps through the eight decoder channels in ascending order, skips channels cleared in a mask, holds each selected channel active for a programmable dwell time, and inserts a blanking gap between channels. Typical uses are multiplexed display digit scanning and one-hot channel strobing; `sel` connects to the decoder's `in` and `en_n` to its active-low `en`.

## Interface
- `DIV_W`, default 8: width of the dwell counter and the `dwell` input.
- `BLANK_CYC`, default 2: number of blanking cycles between channels. Range 0–15; 0 means no gap.
- `clk`  input  1  Single clock. All logic is rising-edge.
- `rst`  input  1  Asynchronous, active-high reset.
- `start`  input  1  Starts a scan when idle. Ignored while `busy`=1.
- `stop`  input  1  Aborts the scan and returns to IDLE. Has priority over `start`.
- `mask`  input  8  Channel enable, bit i = channel i. Sampled live at every channel selection.
- `dwell`  input  DIV_W  Active cycles per channel. 0 is treated as 1. Sampled when a channel is entered.
- `sel`  output  3  Channel index to the decoder `in`. Registered.
- `en_n`  output  1  Active-low decoder enable. Registered; 0 means the channel is driven.
- `busy`  output  1  1 in every state except IDLE.
- `wrap`  output  1  One-cycle pulse when the scan wraps from a higher or equal index back to a lower or equal index.

## Operation
- States: IDLE, DWELL, BLANK. All outputs are registered.
- Reset (asynchronous): state=IDLE, `sel`=3'b000, `en_n`=1, `busy`=0, `wrap`=0, dwell counter=0.
- IDLE: `en_n`=1, `sel` holds its last value.
  - `start`=1, `stop`=0, `mask`≠0 → `sel` = index of the lowest set bit of `mask`, load counter with max(`dwell`,1), go to DWELL.
  - `start` with `mask`=0 → stay in IDLE; no flags are raised.
- DWELL: `en_n`=0. The counter decrements each cycle. When the counter reaches 1:
  - if `BLANK_CYC`>0 → go to BLANK with `en_n`=1;
  - otherwise advance directly, so the next channel is driven with no gap.
- BLANK: `en_n`=1 for exactly `BLANK_CYC` cycles, then advance.
- Advance: the next channel is the first set bit of the current `mask`, searched circularly from `sel`+1 (mod 8).
  - If the next index ≤ current `sel`, assert `wrap` for 1 cycle. This includes a single-bit mask re-selecting the same channel.
  - If `mask`=0 at advance time → go to IDLE with `en_n`=1.
- `stop`=1 in any state → next edge: IDLE, `en_n`=1, `wrap`=0. `sel` is held.
- A change to `dwell` mid-channel does not affect the channel currently active.
- A change to `mask` mid-channel does not cut the current channel short; it only affects the next selection.

## Timing
- A `start` sampled at edge N produces `busy`=1, `en_n`=0 and a valid `sel` in the cycle after edge N.
- Per-channel period is D + `BLANK_CYC` cycles, where D = max(`dwell`,1). `en_n` is low for exactly D cycles.
- `sel` changes only while `en_n`=1 (during BLANK or at entry), except when `BLANK_CYC`=0. In that case `sel` changes at the same edge as the dwell boundary and `en_n` stays 0.
- `wrap` is asserted in the first cycle of the new channel.
- `busy` deasserts in the cycle after `stop` is sampled, or in the cycle after the mask-empty advance.
- Reset mid-scan forces `en_n`=1 immediately, without waiting for a clock edge.

## Test plan
- Reset then idle: `rst` pulse → `sel`=000, `en_n`=1, `busy`=0. `start` with `mask`=8'h00 → `busy` stays 0.
- Full scan: `mask`=8'hFF, `dwell`=3, `BLANK_CYC`=2, one `start` pulse.
  - `sel` steps 0,1,…,7,0 with `en_n` low 3 cycles and high 2 cycles per channel (period 5).
  - `wrap` pulses once when 7→0.
- Sparse mask: `mask`=8'b1010_0100, `dwell`=1.
  - Sequence is `sel`=2,5,7,2,…; `wrap` pulses on each return to 2.
  - `dwell`=0 gives the same timing as `dwell`=1.
- Single channel with `BLANK_CYC`=0: `mask`=8'h10, `dwell`=4.
  - `sel` stays 4 and `en_n` stays 0 continuously.
  - `wrap` pulses every 4 cycles.
- Stop/start priority:
  - `stop` asserted mid-DWELL → next cycle `en_n`=1, `busy`=0.
  - `start` and `stop` together in IDLE → stays IDLE.
  - `start` while busy → no restart; the sequence is unchanged.
- Mask cleared and async reset mid-scan:
  - `mask`→0 during DWELL of channel 3 → channel 3 completes its dwell and blank, then IDLE.
  - `rst` asserted between clock edges during DWELL → `en_n`=1 and `sel`=000 immediately.
